// File: rtl/mycpu_exe_stage.sv
// rtl/mycpu_exe_stage.sv - execute stage: latches one instruction, drives the ALU, flags overflow
// Only the valid flag is cleared by flush; the fields may still load and are simply ignored.
module mycpu_exe_stage #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [4:0] EXCODE_OV  = 5'h0c
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  ds_to_es_valid,
  output logic                  es_allowin,
  input  logic [31:0]           ds_pc,
  input  logic [3:0]            ds_alu_op,
  input  logic [DATA_WIDTH-1:0] ds_src1,
  input  logic [DATA_WIDTH-1:0] ds_src2,
  input  logic [DATA_WIDTH-1:0] ds_imm,
  input  logic                  ds_src2_is_imm,
  input  logic                  ds_ov_en,
  input  logic                  ds_gr_we,
  input  logic [4:0]            ds_dest,
  input  logic                  ds_mem_we,
  input  logic                  ds_mem_re,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [3:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_overflow,
  input  logic                  ms_allowin,
  output logic                  es_to_ms_valid,
  output logic [31:0]           es_pc,
  output logic [DATA_WIDTH-1:0] es_alu_result,
  output logic [DATA_WIDTH-1:0] es_store_data,
  output logic                  es_gr_we,
  output logic                  es_mem_we,
  output logic                  es_mem_re,
  output logic [4:0]            es_dest,
  output logic                  es_ex,
  output logic [4:0]            es_excode,
  output logic [4:0]            es_fwd_dest,
  output logic                  es_fwd_is_load
);

  logic                  es_valid_d, es_valid_q;
  logic [31:0]           pc_d, pc_q;
  logic [3:0]            alu_op_d, alu_op_q;
  logic [DATA_WIDTH-1:0] src1_d, src1_q;
  logic [DATA_WIDTH-1:0] src2_d, src2_q;
  logic [DATA_WIDTH-1:0] imm_d, imm_q;
  logic                  src2_is_imm_d, src2_is_imm_q;
  logic                  ov_en_d, ov_en_q;
  logic                  gr_we_d, gr_we_q;
  logic [4:0]            dest_d, dest_q;
  logic                  mem_we_d, mem_we_q;
  logic                  mem_re_d, mem_re_q;
  logic                  load_en;

  assign es_allowin = !es_valid_q || ms_allowin;
  assign load_en    = ds_to_es_valid && es_allowin;

  always_comb begin
    es_valid_d    = es_valid_q;
    pc_d          = pc_q;
    alu_op_d      = alu_op_q;
    src1_d        = src1_q;
    src2_d        = src2_q;
    imm_d         = imm_q;
    src2_is_imm_d = src2_is_imm_q;
    ov_en_d       = ov_en_q;
    gr_we_d       = gr_we_q;
    dest_d        = dest_q;
    mem_we_d      = mem_we_q;
    mem_re_d      = mem_re_q;
    if (flush) begin
      es_valid_d = 1'b0;
    end else if (es_allowin) begin
      es_valid_d = ds_to_es_valid;
    end
    if (load_en) begin
      pc_d          = ds_pc;
      alu_op_d      = ds_alu_op;
      src1_d        = ds_src1;
      src2_d        = ds_src2;
      imm_d         = ds_imm;
      src2_is_imm_d = ds_src2_is_imm;
      ov_en_d       = ds_ov_en;
      gr_we_d       = ds_gr_we;
      dest_d        = ds_dest;
      mem_we_d      = ds_mem_we;
      mem_re_d      = ds_mem_re;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid_q    <= 1'b0;
      pc_q          <= '0;
      alu_op_q      <= '0;
      src1_q        <= '0;
      src2_q        <= '0;
      imm_q         <= '0;
      src2_is_imm_q <= 1'b0;
      ov_en_q       <= 1'b0;
      gr_we_q       <= 1'b0;
      dest_q        <= '0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
    end else begin
      es_valid_q    <= es_valid_d;
      pc_q          <= pc_d;
      alu_op_q      <= alu_op_d;
      src1_q        <= src1_d;
      src2_q        <= src2_d;
      imm_q         <= imm_d;
      src2_is_imm_q <= src2_is_imm_d;
      ov_en_q       <= ov_en_d;
      gr_we_q       <= gr_we_d;
      dest_q        <= dest_d;
      mem_we_q      <= mem_we_d;
      mem_re_q      <= mem_re_d;
    end
  end

  // ALU inputs come only from latched fields so a stalled result stays stable
  assign alu_a  = src1_q;
  assign alu_b  = src2_is_imm_q ? imm_q : src2_q;
  assign alu_op = alu_op_q;

  assign es_to_ms_valid = es_valid_q && !flush;
  assign es_pc          = pc_q;
  assign es_alu_result  = alu_result;
  assign es_store_data  = src2_q;
  assign es_dest        = dest_q;

  assign es_ex     = es_valid_q && ov_en_q && alu_overflow;
  assign es_excode = es_ex ? EXCODE_OV : 5'd0;

  // A trapping instruction must not commit any architectural side effect
  assign es_gr_we  = es_valid_q && gr_we_q && !es_ex;
  assign es_mem_we = es_valid_q && mem_we_q && !es_ex;
  assign es_mem_re = es_valid_q && mem_re_q && !es_ex;

  assign es_fwd_dest    = es_gr_we ? dest_q : 5'd0;
  assign es_fwd_is_load = es_valid_q && mem_re_q;

endmodule
